instr_cache_line_filler: RTL and testbench
==========================================

# instr_cache_line_filler

Refill engine for the instruction cache: on a miss it fetches one full cache line from the memory side word by word, critical word first with wrap-around, and writes each word into the cache word block through a single-word write port. It sits between the miss-detect logic and the backing instruction memory, and is the write-side counterpart of the combinational word-block read path. The requested word is also forwarded on an early-restart port, so fetch can resume before the line completes.

## Interface
- ADDR_WIDTH, 3, word-offset bits per line; WORD_COUNT = 2**ADDR_WIDTH words (default 8 words, 32 bytes).
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- miss_valid_i  input  1  miss request present.
- miss_addr_i  input  32  byte address of the missing instruction.
- miss_ready_o  output  1  filler idle; a miss is accepted when miss_valid_i & miss_ready_o.
- mem_req_valid_o  output  1  memory read request valid.
- mem_req_addr_o  output  32  word-aligned byte address of the requested word.
- mem_req_ready_i  input  1  memory accepts the request this cycle.
- mem_rsp_valid_i  input  1  read data valid.
- mem_rsp_data_i  input  32  read data.
- wr_en_o  output  1  write strobe to the cache word block.
- wr_addr_o  output  ADDR_WIDTH  word index within the line.
- wr_data_o  output  32  word to write.
- crit_valid_o  output  1  one-cycle pulse: the critical (missed) word is on crit_data_o.
- crit_data_o  output  32  critical word.
- fill_done_o  output  1  one-cycle pulse: the whole line has been written.
- fill_base_o  output  32  line base address of the current or last fill (tag source).

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - miss_ready_o=1.
  - On miss_valid_i, latch base = miss_addr_i with bits [ADDR_WIDTH+1:0] cleared, and idx = miss_addr_i[ADDR_WIDTH+1:2].
  - Clear cnt, then go to REQ.
  - Address bits [1:0] are ignored.
- REQ:
  - mem_req_valid_o=1; mem_req_addr_o = base | (idx << 2).
  - mem_req_ready_i=1 -> WAIT; otherwise hold with address stable.
- WAIT:
  - One outstanding request only.
  - On mem_rsp_valid_i: wr_en_o=1, wr_addr_o=idx and wr_data_o=mem_rsp_data_i, all combinational in the same cycle.
  - On that same response: idx <= idx+1 mod WORD_COUNT (wraps from WORD_COUNT-1 to 0), and cnt <= cnt+1.
  - If cnt==WORD_COUNT-1 -> DONE, else -> REQ.
- The critical word is the first response of a fill (cnt==0). crit_valid_o pulses together with that write; crit_data_o = mem_rsp_data_i.
- DONE: fill_done_o=1 for exactly one cycle, then go to IDLE.
- fill_base_o holds base from acceptance until the next accepted miss.
- cnt width is ADDR_WIDTH+1 bits. Exactly WORD_COUNT writes occur per fill, each line index written once.
- mem_rsp_valid_i is ignored in IDLE, REQ and DONE. A miss_valid_i outside IDLE is not accepted (miss_ready_o=0).
- Reset mid-fill:
  - FSM returns to IDLE; no fill_done_o is issued.
  - Words already written remain in the block. The miss logic must not mark the line valid.

## Timing
- Reset values: FSM IDLE; miss_ready_o=1; mem_req_valid_o, wr_en_o, crit_valid_o, fill_done_o = 0.
- Reset values of data outputs: mem_req_addr_o, fill_base_o, crit_data_o, wr_data_o, wr_addr_o = 0.
- Miss accepted at edge 0 -> mem_req_valid_o high in cycle 1.
- Minimum 2 cycles per word: REQ with ready=1, then WAIT with the response in its first cycle.
- Zero-stall fill: fill_done_o in cycle 2*WORD_COUNT+1 (cycle 17 for the default); miss_ready_o high again in the following cycle.
- The critical word is written and forwarded at the earliest in cycle 2.

## Test plan
- Reset, then miss_addr_i=0x0000_1000, ready=1, response one cycle after each request:
  - writes go to idx 0..7 in order;
  - request addresses are 0x1000..0x101C;
  - crit_valid_o pulses in cycle 2;
  - fill_done_o pulses in cycle 17;
  - fill_base_o=0x1000.
- Critical-word wrap, miss_addr_i=0x0000_2017 (idx 5):
  - request addresses are 0x2014, 0x2018, 0x201C, 0x2000 … 0x2010;
  - wr_addr_o sequence is 5,6,7,0,1,2,3,4;
  - crit_data_o equals the first response.
- Backpressure: mem_req_ready_i low for 3 cycles on word 2 -> mem_req_addr_o is stable and no write occurs; then the fill completes with 8 writes.
- Stray traffic:
  - mem_rsp_valid_i pulsed in IDLE and REQ -> no wr_en_o;
  - miss_valid_i asserted mid-fill -> miss_ready_o=0 and the miss is not accepted until after DONE.
- Reset mid-fill: rst_i high after the 3rd write -> next cycle the FSM is IDLE, all strobes are 0, and no fill_done_o is issued; a new miss then fills normally.

Source files
------------

// File: rtl/instr_cache_line_filler.sv
// Instruction-cache line refill engine: fetches one full line from memory,
// critical word first with wrap-around, and streams each word into the word block.
module instr_cache_line_filler #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  miss_valid_i,
    input  logic [31:0]           miss_addr_i,
    output logic                  miss_ready_o,
    output logic                  mem_req_valid_o,
    output logic [31:0]           mem_req_addr_o,
    input  logic                  mem_req_ready_i,
    input  logic                  mem_rsp_valid_i,
    input  logic [31:0]           mem_rsp_data_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [31:0]           wr_data_o,
    output logic                  crit_valid_o,
    output logic [31:0]           crit_data_o,
    output logic                  fill_done_o,
    output logic [31:0]           fill_base_o
);

    localparam int WORD_COUNT = 2 ** ADDR_WIDTH;
    localparam int CNT_WIDTH  = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(WORD_COUNT - 1);
    localparam logic [31:0] OFFSET_MASK = 32'((64'd1 << (ADDR_WIDTH + 2)) - 64'd1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e                state_q, state_d;
    logic [31:0]           base_q, base_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  rsp_fire;

    assign rsp_fire = (state_q == WAIT) && mem_rsp_valid_i;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (miss_valid_i) begin
                    base_d  = miss_addr_i & ~OFFSET_MASK;
                    idx_d   = miss_addr_i[ADDR_WIDTH+1:2];
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // idx wraps naturally at WORD_COUNT, giving the critical-word-first order
                if (mem_rsp_valid_i) begin
                    idx_d   = idx_q + ADDR_WIDTH'(1);
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = (cnt_q == LAST_CNT) ? DONE : REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            base_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign miss_ready_o    = (state_q == IDLE);
    assign mem_req_valid_o = (state_q == REQ);
    assign mem_req_addr_o  = base_q | {{(32-ADDR_WIDTH-2){1'b0}}, idx_q, 2'b00};
    assign fill_done_o     = (state_q == DONE);
    assign fill_base_o     = base_q;

    // Write port and early-restart data are zeroed whenever no response is being taken
    assign wr_en_o      = rsp_fire;
    assign wr_addr_o    = rsp_fire ? idx_q : '0;
    assign wr_data_o    = rsp_fire ? mem_rsp_data_i : '0;
    assign crit_valid_o = rsp_fire && (cnt_q == '0);
    assign crit_data_o  = crit_valid_o ? mem_rsp_data_i : '0;

endmodule

// File: tb/tb_instr_cache_line_filler.sv
// Directed self-checking bench for instr_cache_line_filler: one task per scenario,
// with a simple one-outstanding-request memory responder inside runCycle.
module tb_instr_cache_line_filler;

    localparam int AW = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          miss_valid_i;
    logic [31:0]   miss_addr_i;
    logic          miss_ready_o;
    logic          mem_req_valid_o;
    logic [31:0]   mem_req_addr_o;
    logic          mem_req_ready_i;
    logic          mem_rsp_valid_i;
    logic [31:0]   mem_rsp_data_i;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [31:0]   wr_data_o;
    logic          crit_valid_o;
    logic [31:0]   crit_data_o;
    logic          fill_done_o;
    logic [31:0]   fill_base_o;

    int checkCount = 0;
    int passCount  = 0;

    int            cycleNum;
    logic          rspPending;
    logic [31:0]   rspAddr;
    logic [31:0]   reqLog[$];
    logic [AW-1:0] wrAddrLog[$];
    logic [31:0]   wrDataLog[$];
    int            critCount, critCycle, doneCount, doneCycle;
    logic [31:0]   critData;
    logic          sMissReady, sReqValid, sWrEn, sCritValid, sFillDone;
    logic [31:0]   sReqAddr, sFillBase;

    instr_cache_line_filler #(.ADDR_WIDTH(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .miss_valid_i(miss_valid_i), .miss_addr_i(miss_addr_i), .miss_ready_o(miss_ready_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_ready_i(mem_req_ready_i),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .crit_valid_o(crit_valid_o), .crit_data_o(crit_data_o),
        .fill_done_o(fill_done_o), .fill_base_o(fill_base_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {16'hCAFE, a[15:0]} ^ 32'h0000_5A5A;
    endfunction

    task automatic clearLogs();
        cycleNum   = 0;
        rspPending = 1'b0;
        rspAddr    = '0;
        reqLog.delete();
        wrAddrLog.delete();
        wrDataLog.delete();
        critCount  = 0;
        critCycle  = -1;
        doneCount  = 0;
        doneCycle  = -1;
        critData   = '0;
    endtask

    // Called just after a rising edge; drives one cycle of inputs, samples on the falling edge.
    task automatic runCycle(input logic ready, input logic strayRsp);
        cycleNum++;
        mem_req_ready_i = ready;
        mem_rsp_valid_i = rspPending | strayRsp;
        mem_rsp_data_i  = rspPending ? memWord(rspAddr) : 32'hBAD0_BAD0;
        rspPending      = 1'b0;
        @(negedge clk_i);
        sMissReady = miss_ready_o;
        sReqValid  = mem_req_valid_o;
        sReqAddr   = mem_req_addr_o;
        sWrEn      = wr_en_o;
        sCritValid = crit_valid_o;
        sFillDone  = fill_done_o;
        sFillBase  = fill_base_o;
        if (mem_req_valid_o && mem_req_ready_i) begin
            rspPending = 1'b1;
            rspAddr    = mem_req_addr_o;
            reqLog.push_back(mem_req_addr_o);
        end
        if (wr_en_o) begin
            wrAddrLog.push_back(wr_addr_o);
            wrDataLog.push_back(wr_data_o);
        end
        if (crit_valid_o) begin
            critCount++;
            critCycle = cycleNum;
            critData  = crit_data_o;
        end
        if (fill_done_o) begin
            doneCount++;
            doneCycle = cycleNum;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic startMiss(input logic [31:0] addr);
        miss_valid_i    = 1'b1;
        miss_addr_i     = addr;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        miss_valid_i = 1'b0;
        clearLogs();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        miss_valid_i = 1'b0; miss_addr_i = '0;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checkCount++; if (miss_ready_o !== 1'b1) $display("[TB] FAIL reset_miss_ready: got %b expected 1", miss_ready_o); else passCount++;
        checkCount++; if (mem_req_valid_o !== 1'b0) $display("[TB] FAIL reset_req_valid: got %b expected 0", mem_req_valid_o); else passCount++;
        checkCount++; if (wr_en_o !== 1'b0) $display("[TB] FAIL reset_wr_en: got %b expected 0", wr_en_o); else passCount++;
        checkCount++; if (crit_valid_o !== 1'b0) $display("[TB] FAIL reset_crit_valid: got %b expected 0", crit_valid_o); else passCount++;
        checkCount++; if (fill_done_o !== 1'b0) $display("[TB] FAIL reset_fill_done: got %b expected 0", fill_done_o); else passCount++;
        checkCount++; if (mem_req_addr_o !== 32'h0) $display("[TB] FAIL reset_req_addr: got %h expected 0", mem_req_addr_o); else passCount++;
        checkCount++; if (fill_base_o !== 32'h0) $display("[TB] FAIL reset_fill_base: got %h expected 0", fill_base_o); else passCount++;
        checkCount++; if (crit_data_o !== 32'h0) $display("[TB] FAIL reset_crit_data: got %h expected 0", crit_data_o); else passCount++;
        checkCount++; if (wr_data_o !== 32'h0) $display("[TB] FAIL reset_wr_data: got %h expected 0", wr_data_o); else passCount++;
        checkCount++; if (wr_addr_o !== '0) $display("[TB] FAIL reset_wr_addr: got %0d expected 0", wr_addr_o); else passCount++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_basic_fill();
        logic [31:0] ea;
        startMiss(32'h0000_1000);
        for (int c = 1; c <= 17; c++) runCycle(1'b1, 1'b0);
        checkCount++; if (sFillDone !== 1'b1 || sMissReady !== 1'b0) $display("[TB] FAIL basic_cycle17: got done=%b ready=%b expected done=1 ready=0", sFillDone, sMissReady); else passCount++;
        runCycle(1'b1, 1'b0);
        checkCount++; if (sMissReady !== 1'b1) $display("[TB] FAIL basic_ready_after_done: got %b expected 1", sMissReady); else passCount++;
        checkCount++; if (reqLog.size() !== 8) $display("[TB] FAIL basic_req_count: got %0d expected 8", reqLog.size()); else passCount++;
        checkCount++; if (wrAddrLog.size() !== 8) $display("[TB] FAIL basic_wr_count: got %0d expected 8", wrAddrLog.size()); else passCount++;
        for (int i = 0; i < 8 && i < reqLog.size(); i++) begin
            ea = 32'h1000 + 32'(i * 4);
            checkCount++; if (reqLog[i] !== ea) $display("[TB] FAIL basic_req_addr[%0d]: got %h expected %h", i, reqLog[i], ea); else passCount++;
        end
        for (int i = 0; i < 8 && i < wrAddrLog.size(); i++) begin
            ea = 32'h1000 + 32'(i * 4);
            checkCount++; if (wrAddrLog[i] !== AW'(i)) $display("[TB] FAIL basic_wr_addr[%0d]: got %0d expected %0d", i, wrAddrLog[i], i); else passCount++;
            checkCount++; if (wrDataLog[i] !== memWord(ea)) $display("[TB] FAIL basic_wr_data[%0d]: got %h expected %h", i, wrDataLog[i], memWord(ea)); else passCount++;
        end
        checkCount++; if (critCount !== 1 || critCycle !== 2) $display("[TB] FAIL basic_crit_pulse: got count=%0d cycle=%0d expected count=1 cycle=2", critCount, critCycle); else passCount++;
        checkCount++; if (critData !== memWord(32'h1000)) $display("[TB] FAIL basic_crit_data: got %h expected %h", critData, memWord(32'h1000)); else passCount++;
        checkCount++; if (doneCount !== 1 || doneCycle !== 17) $display("[TB] FAIL basic_done_pulse: got count=%0d cycle=%0d expected count=1 cycle=17", doneCount, doneCycle); else passCount++;
        checkCount++; if (sFillBase !== 32'h1000) $display("[TB] FAIL basic_fill_base: got %h expected 00001000", sFillBase); else passCount++;
    endtask

    task automatic test_crit_wrap();
        logic [31:0]   ea;
        logic [AW-1:0] ei;
        startMiss(32'h0000_2017);
        for (int c = 1; c <= 18; c++) runCycle(1'b1, 1'b0);
        checkCount++; if (reqLog.size() !== 8 || wrAddrLog.size() !== 8) $display("[TB] FAIL wrap_counts: got req=%0d wr=%0d expected 8 and 8", reqLog.size(), wrAddrLog.size()); else passCount++;
        for (int i = 0; i < 8 && i < reqLog.size() && i < wrAddrLog.size(); i++) begin
            ei = AW'((5 + i) % 8);
            ea = 32'h2000 | 32'(((5 + i) % 8) * 4);
            checkCount++; if (reqLog[i] !== ea) $display("[TB] FAIL wrap_req_addr[%0d]: got %h expected %h", i, reqLog[i], ea); else passCount++;
            checkCount++; if (wrAddrLog[i] !== ei) $display("[TB] FAIL wrap_wr_addr[%0d]: got %0d expected %0d", i, wrAddrLog[i], ei); else passCount++;
        end
        checkCount++; if (critData !== memWord(32'h2014)) $display("[TB] FAIL wrap_crit_data: got %h expected %h", critData, memWord(32'h2014)); else passCount++;
        checkCount++; if (sFillBase !== 32'h2000) $display("[TB] FAIL wrap_fill_base: got %h expected 00002000", sFillBase); else passCount++;
        checkCount++; if (doneCount !== 1 || doneCycle !== 17) $display("[TB] FAIL wrap_done_pulse: got count=%0d cycle=%0d expected count=1 cycle=17", doneCount, doneCycle); else passCount++;
    endtask

    task automatic test_backpressure();
        logic rdy;
        startMiss(32'h0000_3000);
        for (int c = 1; c <= 21; c++) begin
            rdy = !(c >= 5 && c <= 7);
            runCycle(rdy, 1'b0);
            if (c >= 5 && c <= 8) begin
                checkCount++; if (sReqValid !== 1'b1) $display("[TB] FAIL bp_req_valid[c%0d]: got %b expected 1", c, sReqValid); else passCount++;
                checkCount++; if (sReqAddr !== 32'h3008) $display("[TB] FAIL bp_req_addr[c%0d]: got %h expected 00003008", c, sReqAddr); else passCount++;
                checkCount++; if (sWrEn !== 1'b0) $display("[TB] FAIL bp_no_write[c%0d]: got %b expected 0", c, sWrEn); else passCount++;
            end
        end
        checkCount++; if (wrAddrLog.size() !== 8) $display("[TB] FAIL bp_wr_count: got %0d expected 8", wrAddrLog.size()); else passCount++;
        for (int i = 0; i < 8 && i < wrAddrLog.size(); i++) begin
            checkCount++; if (wrAddrLog[i] !== AW'(i)) $display("[TB] FAIL bp_wr_addr[%0d]: got %0d expected %0d", i, wrAddrLog[i], i); else passCount++;
        end
        checkCount++; if (doneCount !== 1 || doneCycle !== 20) $display("[TB] FAIL bp_done_pulse: got count=%0d cycle=%0d expected count=1 cycle=20", doneCount, doneCycle); else passCount++;
        checkCount++; if (sMissReady !== 1'b1) $display("[TB] FAIL bp_ready_after_done: got %b expected 1", sMissReady); else passCount++;
    endtask

    task automatic test_stray_traffic();
        clearLogs();
        runCycle(1'b0, 1'b1);
        checkCount++; if (sWrEn !== 1'b0 || sMissReady !== 1'b1) $display("[TB] FAIL stray_idle_rsp: got wr_en=%b ready=%b expected wr_en=0 ready=1", sWrEn, sMissReady); else passCount++;
        startMiss(32'h0000_4000);
        runCycle(1'b0, 1'b1);
        checkCount++; if (sWrEn !== 1'b0 || sReqValid !== 1'b1) $display("[TB] FAIL stray_req_rsp: got wr_en=%b req_valid=%b expected wr_en=0 req_valid=1", sWrEn, sReqValid); else passCount++;
        miss_valid_i = 1'b1;
        miss_addr_i  = 32'h0000_5000;
        for (int c = 2; c <= 18; c++) begin
            runCycle(1'b1, 1'b0);
            checkCount++; if (sMissReady !== 1'b0) $display("[TB] FAIL stray_miss_ready[c%0d]: got %b expected 0", c, sMissReady); else passCount++;
        end
        checkCount++; if (wrAddrLog.size() !== 8 || doneCycle !== 18) $display("[TB] FAIL stray_first_fill: got writes=%0d done_cycle=%0d expected 8 and 18", wrAddrLog.size(), doneCycle); else passCount++;
        checkCount++; if (sFillBase !== 32'h4000) $display("[TB] FAIL stray_base_held: got %h expected 00004000", sFillBase); else passCount++;
        runCycle(1'b0, 1'b0);
        miss_valid_i = 1'b0;
        checkCount++; if (sMissReady !== 1'b1) $display("[TB] FAIL stray_ready_idle: got %b expected 1", sMissReady); else passCount++;
        clearLogs();
        runCycle(1'b1, 1'b0);
        checkCount++; if (sReqValid !== 1'b1 || sReqAddr !== 32'h5000) $display("[TB] FAIL stray_second_req: got valid=%b addr=%h expected valid=1 addr=00005000", sReqValid, sReqAddr); else passCount++;
        checkCount++; if (sFillBase !== 32'h5000) $display("[TB] FAIL stray_second_base: got %h expected 00005000", sFillBase); else passCount++;
        for (int c = 0; c < 40 && doneCount == 0; c++) runCycle(1'b1, 1'b0);
        checkCount++; if (doneCount !== 1 || wrAddrLog.size() !== 8) $display("[TB] FAIL stray_second_fill: got done=%0d writes=%0d expected 1 and 8", doneCount, wrAddrLog.size()); else passCount++;
        runCycle(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_fill();
        logic [AW-1:0] ei;
        startMiss(32'h0000_6000);
        for (int c = 0; c < 20 && wrAddrLog.size() < 3; c++) runCycle(1'b1, 1'b0);
        checkCount++; if (wrAddrLog.size() !== 3) $display("[TB] FAIL rmf_three_writes: got %0d expected 3", wrAddrLog.size()); else passCount++;
        rst_i = 1'b1;
        runCycle(1'b0, 1'b0);
        rst_i = 1'b0;
        runCycle(1'b0, 1'b0);
        checkCount++; if (sMissReady !== 1'b1 || sReqValid !== 1'b0) $display("[TB] FAIL rmf_idle: got ready=%b req_valid=%b expected ready=1 req_valid=0", sMissReady, sReqValid); else passCount++;
        checkCount++; if (sWrEn !== 1'b0 || sCritValid !== 1'b0 || sFillDone !== 1'b0) $display("[TB] FAIL rmf_strobes: got wr=%b crit=%b done=%b expected all 0", sWrEn, sCritValid, sFillDone); else passCount++;
        checkCount++; if (sFillBase !== 32'h0) $display("[TB] FAIL rmf_base_cleared: got %h expected 0", sFillBase); else passCount++;
        repeat (3) runCycle(1'b1, 1'b0);
        checkCount++; if (doneCount !== 0 || wrAddrLog.size() !== 3) $display("[TB] FAIL rmf_no_done: got done=%0d writes=%0d expected 0 and 3", doneCount, wrAddrLog.size()); else passCount++;
        startMiss(32'h0000_7004);
        for (int c = 1; c <= 18; c++) runCycle(1'b1, 1'b0);
        checkCount++; if (wrAddrLog.size() !== 8) $display("[TB] FAIL rmf_refill_count: got %0d expected 8", wrAddrLog.size()); else passCount++;
        for (int i = 0; i < 8 && i < wrAddrLog.size(); i++) begin
            ei = AW'((1 + i) % 8);
            checkCount++; if (wrAddrLog[i] !== ei) $display("[TB] FAIL rmf_refill_wr_addr[%0d]: got %0d expected %0d", i, wrAddrLog[i], ei); else passCount++;
        end
        checkCount++; if (critCycle !== 2 || critData !== memWord(32'h7004)) $display("[TB] FAIL rmf_refill_crit: got cycle=%0d data=%h expected cycle=2 data=%h", critCycle, critData, memWord(32'h7004)); else passCount++;
        checkCount++; if (doneCount !== 1 || doneCycle !== 17) $display("[TB] FAIL rmf_refill_done: got count=%0d cycle=%0d expected count=1 cycle=17", doneCount, doneCycle); else passCount++;
        checkCount++; if (sFillBase !== 32'h7000) $display("[TB] FAIL rmf_refill_base: got %h expected 00007000", sFillBase); else passCount++;
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_crit_wrap();
        test_backpressure();
        test_stray_traffic();
        test_reset_mid_fill();
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
